demux_stream: RTL and testbench
===============================

# demux_stream

Parametrised, registered 1-to-N stream demultiplexer with valid/ready flow control on every port. Each accepted input word is steered to one of N output channels, either by an explicit select (MODE_SEL) or by an internal round-robin pointer (MODE_RR), and is held in a one-entry per-channel output register until that channel's consumer takes it. It is the next-generation replacement for the fixed 4-way combinational demux and sits between a single producer and N independent consumers.

## Interface
- W, 8: data width in bits.
- N, 4: number of output channels, 2..16.
- MODE, 0: 0 = MODE_SEL (use in_sel), 1 = MODE_RR (ignore in_sel, round-robin).
- SEL_W, clog2(N): select width, derived.
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  W  input word.
- in_sel  input  SEL_W  target channel (MODE_SEL only).
- in_valid  input  1  producer has a word.
- in_ready  output  1  word accepted this cycle when in_valid & in_ready.
- out_data  output  N*W  channel k occupies bits [k*W +: W].
- out_valid  output  N  per-channel word held.
- out_ready  input  N  per-channel consumer accepts.
- err_drop  output  1  one-cycle pulse: word with in_sel >= N was accepted and discarded.

## Operation
- Target t = in_sel (MODE_SEL) or rr_ptr (MODE_RR).
- Slot k is free when out_valid[k]=0, or when out_valid[k] & out_ready[k] (drained this cycle).
- in_ready = slot t free; in_ready is 1 when t >= N (MODE_SEL only; illegal target).
- Accept (in_valid & in_ready, t < N): out_data[t] <= in_data, out_valid[t] <= 1 next edge.
- Accept with t >= N: no slot written, err_drop = 1 next cycle, otherwise 0.
- Drain (out_valid[k] & out_ready[k]) with no new write to k: out_valid[k] <= 0; out_data[k] holds its last value.
- Simultaneous drain and write on the same slot: the new word replaces the old one, and out_valid stays 1. This gives full throughput per channel.
- rr_ptr: advances by 1 on every accept and wraps from N-1 to 0. It never advances on a stall. In MODE_SEL it is held at 0.
- Channels are independent: a stall on one channel never blocks another channel's drain.
- in_data and in_sel are ignored while in_valid=0. in_valid=1 with in_ready=0 stalls the producer, and the producer must hold its word.

## Timing
- Reset: out_valid=0, out_data=0, rr_ptr=0, err_drop=0. in_ready then follows the combinational rule, so it is 1 after reset.
- Latency: 1 cycle from accept to out_valid on the target channel.
- Throughput: 1 word/cycle when consumers keep up.
- in_ready depends combinationally on out_ready[t], in_sel and rr_ptr. There is no combinational path from in_valid to in_ready.
- Reset asserted mid-operation: held words are discarded, and all outputs return to reset values on the next edge.

## Structure
- Shared package/header: MODE_SEL=0, MODE_RR=1 constants, and a clog2 function for SEL_W.
- Sub-module demux_slot (W): one-entry register with a write/valid/ready interface, instantiated N times by generate.
- The top level holds the target decode, the in_ready mux, rr_ptr and err_drop.

## Test plan
- Reset, MODE_SEL, N=4, W=8: in_data=0xA5, in_sel=2, in_valid for 1 cycle -> next cycle out_valid=0100, out_data[23:16]=0xA5, others 0.
- Backpressure: fill ch1 with 0x11 while out_ready[1]=0, then send 0x22 to ch1 -> in_ready=0 and ch1 holds 0x11. Raise out_ready[1] -> same cycle in_ready=1, next cycle ch1=0x22.
- Streaming: out_ready=1111, 8 words 0x00..0x07 sent back-to-back to ch3 -> every word accepted, one per cycle, each visible on ch3 one cycle after accept.
- MODE_RR, N=4: 6 words 0x10..0x15, consumers stalled after first take -> ch0..ch3 get 0x10..0x13, 0x14 stalls until ch0 drains, and rr_ptr wraps to 0.
- Illegal select, N=3 (SEL_W=2): in_sel=3, in_data=0x7E -> in_ready=1, err_drop pulses once, out_valid unchanged.
- Reset mid-stream: all slots full, assert rst for 1 cycle -> out_valid=000…0, out_data=0, next RR accept goes to ch0.

Source files
------------

// File: rtl/demux_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux_stream_pkg
//   Shared constants and helpers for the demux_stream block.
//   - MODE_SEL / MODE_RR : steering mode selectors for the MODE parameter
//   - demux_clog2()      : select-width helper (minimum result of 1 bit)
// -----------------------------------------------------------------------------
package demux_stream_pkg;

    localparam int MODE_SEL = 0;  // target channel comes from in_sel
    localparam int MODE_RR  = 1;  // target channel comes from the round-robin pointer

    // Number of bits needed to encode 0..value-1. A single channel still
    // needs one select bit so the port never collapses to zero width.
    function automatic int demux_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
//   One-entry output register for a single demux channel.
//   Handshake: the consumer takes the held word on any rising edge where
//   valid_o & ready_i are both 1. A write (wr_en_i) always lands; the parent
//   only writes when the slot is free (empty, or draining this same cycle),
//   so a write in the drain cycle replaces the old word and valid stays high.
//
//   Ports:
//     clk_i      clock, rising edge
//     rst_i      synchronous active-high reset
//     wr_en_i    load wr_data_i into the slot
//     wr_data_i  word to load (W bits)
//     ready_i    consumer accepts the held word
//     valid_o    slot holds a word
//     data_o     held word (keeps last value after drain)
// -----------------------------------------------------------------------------
module demux_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_en_i) begin
            valid_d = 1'b1;
            data_d  = wr_data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
//   Registered 1-to-N stream demultiplexer. Each accepted input word is
//   steered to one channel (by in_sel or by a round-robin pointer) and held
//   in that channel's one-entry slot until its consumer takes it.
//
//   Handshake (all ports): a word moves on a rising edge where valid and
//   ready are both 1. in_ready is a function of out_valid/out_ready of the
//   target slot, in_sel and the round-robin pointer only -- never in_valid.
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     in_data    input word (W bits)
//     in_sel     target channel, used only when MODE = MODE_SEL
//     in_valid   producer has a word
//     in_ready   target slot can take a word this cycle
//     out_data   channel k at bits [k*W +: W]
//     out_valid  per-channel word held
//     out_ready  per-channel consumer accepts
//     err_drop   one-cycle pulse after a word with an out-of-range select
//                was accepted and discarded
// -----------------------------------------------------------------------------
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int MODE  = MODE_SEL,
    parameter int SEL_W = demux_clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N*W-1:0]   out_data,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic             err_drop
);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] tgt;
    logic [N-1:0]     slot_free;
    logic [N-1:0]     wr_en;
    logic             tgt_hit;
    logic             accept;
    logic             err_drop_q, err_drop_d;

    assign tgt = (MODE == MODE_RR) ? rr_ptr_q : in_sel;

    // A slot is free when empty or being drained this cycle. An out-of-range
    // target matches no slot: in_ready stays 1 so the word is swallowed.
    always_comb begin
        slot_free = ~out_valid | out_ready;
        tgt_hit   = 1'b0;
        in_ready  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (tgt == SEL_W'(k)) begin
                tgt_hit  = 1'b1;
                in_ready = slot_free[k];
            end
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        wr_en = '0;
        for (int k = 0; k < N; k++) begin
            wr_en[k] = accept & (tgt == SEL_W'(k));
        end
    end

    // The pointer only moves on an accept, so a stalled word keeps its target.
    // In MODE_SEL it stays at its reset value of 0.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((MODE == MODE_RR) && accept) begin
            rr_ptr_d = (rr_ptr_q == SEL_W'(N - 1)) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end

    assign err_drop_d = accept & ~tgt_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            err_drop_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            err_drop_q <= err_drop_d;
        end
    end

    assign err_drop = err_drop_q;

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(
            .W(W)
        ) u_slot (
            .clk_i     (clk),
            .rst_i     (rst),
            .wr_en_i   (wr_en[k]),
            .wr_data_i (in_data),
            .ready_i   (out_ready[k]),
            .valid_o   (out_valid[k]),
            .data_o    (out_data[k*W +: W])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;
    import demux_stream_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT: select mode, N=4 ----------------
    logic [7:0]  s4_in_data;
    logic [1:0]  s4_in_sel;
    logic        s4_in_valid;
    logic        s4_in_ready;
    logic [31:0] s4_out_data;
    logic [3:0]  s4_out_valid;
    logic [3:0]  s4_out_ready;
    logic        s4_err_drop;

    demux_stream #(.W(8), .N(4), .MODE(MODE_SEL)) u_sel4 (
        .clk(clk), .rst(rst),
        .in_data(s4_in_data), .in_sel(s4_in_sel), .in_valid(s4_in_valid),
        .in_ready(s4_in_ready), .out_data(s4_out_data), .out_valid(s4_out_valid),
        .out_ready(s4_out_ready), .err_drop(s4_err_drop)
    );

    // ---------------- DUT: round-robin mode, N=4 ----------------
    logic [7:0]  r4_in_data;
    logic [1:0]  r4_in_sel;
    logic        r4_in_valid;
    logic        r4_in_ready;
    logic [31:0] r4_out_data;
    logic [3:0]  r4_out_valid;
    logic [3:0]  r4_out_ready;
    logic        r4_err_drop;

    demux_stream #(.W(8), .N(4), .MODE(MODE_RR)) u_rr4 (
        .clk(clk), .rst(rst),
        .in_data(r4_in_data), .in_sel(r4_in_sel), .in_valid(r4_in_valid),
        .in_ready(r4_in_ready), .out_data(r4_out_data), .out_valid(r4_out_valid),
        .out_ready(r4_out_ready), .err_drop(r4_err_drop)
    );

    // ---------------- DUT: select mode, N=3 ----------------
    logic [7:0]  s3_in_data;
    logic [1:0]  s3_in_sel;
    logic        s3_in_valid;
    logic        s3_in_ready;
    logic [23:0] s3_out_data;
    logic [2:0]  s3_out_valid;
    logic [2:0]  s3_out_ready;
    logic        s3_err_drop;

    demux_stream #(.W(8), .N(3), .MODE(MODE_SEL)) u_sel3 (
        .clk(clk), .rst(rst),
        .in_data(s3_in_data), .in_sel(s3_in_sel), .in_valid(s3_in_valid),
        .in_ready(s3_in_ready), .out_data(s3_out_data), .out_valid(s3_out_valid),
        .out_ready(s3_out_ready), .err_drop(s3_err_drop)
    );

    // ---------------- checking ----------------
    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin DUT: drive, check in_ready before the edge, outputs after.
    task automatic rr_step(input string name, input logic [7:0] d, input logic v,
                           input logic [3:0] rdy, input logic exp_ir,
                           input logic [3:0] exp_ov, input logic [31:0] exp_od);
        r4_in_data   = d;
        r4_in_valid  = v;
        r4_out_ready = rdy;
        #3;
        chk({name, "_in_ready"}, r4_in_ready, exp_ir);
        tick();
        chk({name, "_out_valid"}, r4_out_valid, exp_ov);
        chk({name, "_out_data"}, r4_out_data, exp_od);
    endtask

    task automatic s3_step(input string name, input logic [7:0] d, input logic [1:0] sel,
                           input logic v, input logic exp_ir, input logic [2:0] exp_ov,
                           input logic [23:0] exp_od, input logic exp_err);
        s3_in_data  = d;
        s3_in_sel   = sel;
        s3_in_valid = v;
        #3;
        chk({name, "_in_ready"}, s3_in_ready, exp_ir);
        tick();
        chk({name, "_out_valid"}, s3_out_valid, exp_ov);
        chk({name, "_out_data"}, s3_out_data, exp_od);
        chk({name, "_err_drop"}, s3_err_drop, exp_err);
    endtask

    // ---------------- vector table for the N=4 select DUT ----------------
    typedef struct packed {
        logic [7:0]  d;
        logic [1:0]  sel;
        logic        v;
        logic [3:0]  rdy;
        logic        exp_ir;   // in_ready before the edge
        logic [3:0]  exp_ov;   // out_valid after the edge
        logic [31:0] exp_od;   // out_data after the edge
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    initial begin
        // basic write to ch2, then drain it
        vecs[0] = '{8'hA5, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000};
        vecs[1] = '{8'h00, 2'd0, 1'b0, 4'b0100, 1'b1, 4'b0000, 32'h00A5_0000};
        // backpressure on ch1
        vecs[2] = '{8'h11, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0010, 32'h00A5_1100};
        vecs[3] = '{8'h22, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0010, 32'h00A5_1100};
        vecs[4] = '{8'h22, 2'd1, 1'b1, 4'b0010, 1'b1, 4'b0010, 32'h00A5_2200};
        vecs[5] = '{8'h00, 2'd0, 1'b0, 4'b0010, 1'b1, 4'b0000, 32'h00A5_2200};
        // back-to-back streaming into ch3
        for (int i = 0; i < 8; i++) begin
            vecs[6 + i] = '{8'(i), 2'd3, 1'b1, 4'b1111, 1'b1, 4'b1000,
                            {8'(i), 8'hA5, 8'h22, 8'h00}};
        end
        vecs[14] = '{8'h00, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h07A5_2200};
        // channel independence: ch0 stalled while ch1 streams
        vecs[15] = '{8'h30, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'h07A5_2230};
        vecs[16] = '{8'h31, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 32'h07A5_3130};
        vecs[17] = '{8'h32, 2'd1, 1'b1, 4'b0010, 1'b1, 4'b0011, 32'h07A5_3230};
        vecs[18] = '{8'h33, 2'd0, 1'b1, 4'b0010, 1'b0, 4'b0001, 32'h07A5_3230};

        // ---- reset ----
        rst          = 1'b1;
        s4_in_data   = '0; s4_in_sel = '0; s4_in_valid = 1'b0; s4_out_ready = '0;
        r4_in_data   = '0; r4_in_sel = 2'd3; r4_in_valid = 1'b0; r4_out_ready = '0;
        s3_in_data   = '0; s3_in_sel = '0; s3_in_valid = 1'b0; s3_out_ready = '0;
        tick();
        tick();
        chk("rst_s4_out_valid", s4_out_valid, 4'b0000);
        chk("rst_s4_out_data",  s4_out_data, 32'h0);
        chk("rst_s4_err_drop",  s4_err_drop, 1'b0);
        chk("rst_r4_out_valid", r4_out_valid, 4'b0000);
        chk("rst_s3_out_valid", s3_out_valid, 3'b000);
        rst = 1'b0;
        #3;
        chk("rst_s4_in_ready", s4_in_ready, 1'b1);
        chk("rst_r4_in_ready", r4_in_ready, 1'b1);
        tick();

        // ---- table-driven select-mode vectors ----
        for (int i = 0; i < NVEC; i++) begin
            s4_in_data   = vecs[i].d;
            s4_in_sel    = vecs[i].sel;
            s4_in_valid  = vecs[i].v;
            s4_out_ready = vecs[i].rdy;
            #3;
            chk($sformatf("vec%0d_in_ready", i), s4_in_ready, vecs[i].exp_ir);
            tick();
            chk($sformatf("vec%0d_out_valid", i), s4_out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d_out_data", i), s4_out_data, vecs[i].exp_od);
            chk($sformatf("vec%0d_err_drop", i), s4_err_drop, 1'b0);
        end
        s4_in_valid  = 1'b0;
        s4_out_ready = 4'b0000;

        // ---- round-robin: fill all four, stall, drain ch0, wrap ----
        rr_step("rr_w10", 8'h10, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'h0000_0010);
        rr_step("rr_w11", 8'h11, 1'b1, 4'b0000, 1'b1, 4'b0011, 32'h0000_1110);
        rr_step("rr_w12", 8'h12, 1'b1, 4'b0000, 1'b1, 4'b0111, 32'h0012_1110);
        rr_step("rr_w13", 8'h13, 1'b1, 4'b0000, 1'b1, 4'b1111, 32'h1312_1110);
        rr_step("rr_stall_a", 8'h14, 1'b1, 4'b0000, 1'b0, 4'b1111, 32'h1312_1110);
        rr_step("rr_stall_b", 8'h14, 1'b1, 4'b0000, 1'b0, 4'b1111, 32'h1312_1110);
        rr_step("rr_wrap14", 8'h14, 1'b1, 4'b0001, 1'b1, 4'b1111, 32'h1312_1114);
        rr_step("rr_stall15", 8'h15, 1'b1, 4'b0000, 1'b0, 4'b1111, 32'h1312_1114);
        rr_step("rr_w15", 8'h15, 1'b1, 4'b0010, 1'b1, 4'b1111, 32'h1312_1514);
        r4_in_valid  = 1'b0;
        r4_out_ready = 4'b0000;

        // ---- illegal select on the N=3 DUT ----
        s3_step("s3_w44", 8'h44, 2'd2, 1'b1, 1'b1, 3'b100, 24'h44_0000, 1'b0);
        s3_step("s3_ill", 8'h7E, 2'd3, 1'b1, 1'b1, 3'b100, 24'h44_0000, 1'b1);
        s3_step("s3_idle", 8'h00, 2'd0, 1'b0, 1'b1, 3'b100, 24'h44_0000, 1'b0);
        s3_in_valid = 1'b0;

        // ---- reset mid-stream: RR DUT full, pointer not at 0 ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_r4_out_valid", r4_out_valid, 4'b0000);
        chk("mid_rst_r4_out_data",  r4_out_data, 32'h0);
        chk("mid_rst_s4_out_valid", s4_out_valid, 4'b0000);
        chk("mid_rst_s4_out_data",  s4_out_data, 32'h0);
        chk("mid_rst_s3_out_valid", s3_out_valid, 3'b000);
        rr_step("rr_post_rst_a", 8'h55, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'h0000_0055);
        rr_step("rr_post_rst_b", 8'h56, 1'b1, 4'b0000, 1'b1, 4'b0011, 32'h0000_5655);
        r4_in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
